// File: rtl/des_ks_pkg.sv
// Shared constants and helpers for the DES key schedule: PC1/PC2 tables
// (1-based DES bit numbering, bit 1 = MSB), default shift schedule,
// schedule total helper, and the FSM state type.
package des_ks_pkg;

  localparam int ROUND_W = 4;

  typedef enum logic {IDLE, RUN} ks_state_e;

  // Standard DES rotate amounts 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; round 1 in the MSB field
  localparam logic [31:0] DES_SHIFT_SCHED = 32'h5AAA_6AA9;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Sum of the first 'rounds' schedule entries, modulo the 28-bit half width
  function automatic int sched_total(input logic [31:0] sched, input int rounds);
    int sum;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < rounds) sum += int'(sched[2*i +: 2]);
    end
    return sum % 28;
  endfunction

  // PC1: 64-bit key (parity bits dropped) to 56-bit {C,D}
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1_TAB[i]];
    return r;
  endfunction

  // PC2: 56-bit {C,D} to 48-bit subkey
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
    return r;
  endfunction

  // 28-bit circular left rotate; used only with elaboration-time amounts
  function automatic logic [27:0] rotl28(input logic [27:0] x, input int n);
    logic [55:0] t;
    t = {x, x} << (n % 28);
    return t[55:28];
  endfunction

endpackage

// File: rtl/des_key_schedule_stream_if.sv
// Key-in / subkey-out handshake bundle for the streaming key schedule.
// master = key source and subkey consumer, slave = the key schedule.
interface des_key_schedule_stream_if;
  import des_ks_pkg::*;

  logic               key_valid;
  logic               key_ready;
  logic [63:0]        key;
  logic               decrypt;
  logic               sk_valid;
  logic               sk_ready;
  logic [47:0]        sk_data;
  logic [ROUND_W-1:0] sk_round;
  logic               sk_last;
  logic               busy;

  modport master (
    output key_valid, key, decrypt, sk_ready,
    input  key_ready, sk_valid, sk_data, sk_round, sk_last, busy
  );

  modport slave (
    input  key_valid, key, decrypt, sk_ready,
    output key_ready, sk_valid, sk_data, sk_round, sk_last, busy
  );

endinterface

// File: rtl/des_ks_rotator.sv
// 28-bit circular rotator for one key half: dir 0 = left, 1 = right,
// amount 0..2 (0 passes the half through unchanged).
module des_ks_rotator
  import des_ks_pkg::*;
(
  input  logic [27:0] value,
  input  logic        dir,
  input  logic [1:0]  amt,
  output logic [27:0] result
);

  // Select the rotated half by direction and amount
  always_comb begin
    result = value;
    case (amt)
      2'd1:    result = dir ? {value[0], value[27:1]}   : {value[26:0], value[27]};
      2'd2:    result = dir ? {value[1:0], value[27:2]} : {value[25:0], value[27:26]};
      default: result = value;
    endcase
  end

endmodule

// File: rtl/des_key_schedule_stream.sv
// Streaming DES key schedule: loads a key, then emits one PC2 subkey per
// accepted beat in encrypt (K1..Kn) or decrypt (Kn..K1) order, with
// back-pressure and zero-bubble reload on the last beat.
module des_key_schedule_stream
  import des_ks_pkg::*;
#(
  parameter int                  ROUNDS      = 16,
  parameter logic [2*ROUNDS-1:0] SHIFT_SCHED = DES_SHIFT_SCHED
) (
  input  logic                     clk,
  input  logic                     rst,
  des_key_schedule_stream_if.slave bus
);

  // Load rotations: first schedule entry for encrypt, whole-schedule total for decrypt
  localparam int ENC_LOAD = int'(SHIFT_SCHED[2*ROUNDS-2 +: 2]);
  localparam int DEC_LOAD = sched_total(32'(SHIFT_SCHED), ROUNDS);
  localparam logic [ROUND_W-1:0] PENULT = (ROUNDS >= 2) ? ROUND_W'(ROUNDS - 2) : '0;
  localparam logic FIRST_IS_LAST = (ROUNDS == 1);

  if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
    $error("des_key_schedule_stream: ROUNDS must be in 1..16");
  end

  for (genvar g = 0; g < ROUNDS; g++) begin : g_chk
    if (SHIFT_SCHED[2*g +: 2] == 2'd3) begin : g_bad_shift
      $error("des_key_schedule_stream: SHIFT_SCHED entries must be 0..2");
    end
  end

  ks_state_e          state;
  logic [27:0]        c_reg, d_reg;
  logic [27:0]        c_step, d_step;
  logic [27:0]        c_load, d_load;
  logic [55:0]        pc1_key;
  logic [ROUND_W-1:0] round_cnt;
  logic               valid_reg, last_reg, busy_reg, mode_reg;
  logic               key_rdy, accept, take;
  logic [1:0]         enc_tab [16];
  logic [1:0]         dec_tab [16];
  logic [1:0]         step_amt;

  // Per-position step amounts, indexed by the current 0-based stream position.
  // Encrypt moves K(p+1) -> K(p+2) using entry p+2; decrypt moves K(n-p) -> K(n-p-1)
  // using entry n-p, which sits at bit 2*p of the schedule.
  for (genvar g = 0; g < 16; g++) begin : g_tab
    if (g + 2 <= ROUNDS) begin : g_enc
      assign enc_tab[g] = SHIFT_SCHED[2*(ROUNDS-g-2) +: 2];
    end else begin : g_enc_none
      assign enc_tab[g] = 2'd0;
    end
    if (g < ROUNDS) begin : g_dec
      assign dec_tab[g] = SHIFT_SCHED[2*g +: 2];
    end else begin : g_dec_none
      assign dec_tab[g] = 2'd0;
    end
  end

  assign pc1_key = pc1(bus.key);
  assign c_load  = bus.decrypt ? rotl28(pc1_key[55:28], DEC_LOAD) : rotl28(pc1_key[55:28], ENC_LOAD);
  assign d_load  = bus.decrypt ? rotl28(pc1_key[27:0], DEC_LOAD)  : rotl28(pc1_key[27:0], ENC_LOAD);

  assign step_amt = mode_reg ? dec_tab[round_cnt] : enc_tab[round_cnt];

  des_ks_rotator u_rot_c (
    .value  (c_reg),
    .dir    (mode_reg),
    .amt    (step_amt),
    .result (c_step)
  );

  des_ks_rotator u_rot_d (
    .value  (d_reg),
    .dir    (mode_reg),
    .amt    (step_amt),
    .result (d_step)
  );

  // A key is taken when idle or in the same cycle the last subkey is consumed
  assign key_rdy = !rst && ((state == IDLE) || (last_reg && bus.sk_ready));
  assign accept  = bus.key_valid && key_rdy;
  assign take    = valid_reg && bus.sk_ready;

  // Control FSM plus C/D state; accept takes priority so a last-beat reload has no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      last_reg  <= 1'b0;
      round_cnt <= '0;
      mode_reg  <= 1'b0;
      c_reg     <= '0;
      d_reg     <= '0;
    end else if (accept) begin
      state     <= RUN;
      valid_reg <= 1'b1;
      busy_reg  <= 1'b1;
      last_reg  <= FIRST_IS_LAST;
      round_cnt <= '0;
      mode_reg  <= bus.decrypt;
      c_reg     <= c_load;
      d_reg     <= d_load;
    end else if (take) begin
      if (last_reg) begin
        state     <= IDLE;
        valid_reg <= 1'b0;
        busy_reg  <= 1'b0;
        last_reg  <= 1'b0;
        round_cnt <= '0;
      end else begin
        round_cnt <= round_cnt + ROUND_W'(1);
        last_reg  <= (round_cnt == PENULT);
        c_reg     <= c_step;
        d_reg     <= d_step;
      end
    end
  end

  assign bus.key_ready = key_rdy;
  assign bus.sk_valid  = valid_reg;
  assign bus.sk_data   = pc2({c_reg, d_reg});
  assign bus.sk_round  = round_cnt;
  assign bus.sk_last   = last_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_des_key_schedule_stream.sv
// Directed bench for des_key_schedule_stream: DES reference subkeys for
// key 133457799BBCDFF1, plus an 8-round instance with a custom schedule.
module tb_des_key_schedule_stream;

  localparam logic [63:0] KEY_A = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] KEY_P = KEY_A ^ 64'h0101_0101_0101_0101;
  localparam logic [63:0] KEY_1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic [47:0] ks_a [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  // Schedule 1,1,2,0,2,2,2,2 lands on DES cumulative shifts 1,2,4,4,6,8,10,12
  logic [47:0] ks_8 [8] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h55FC8A42CF99,
    48'h72ADD6DB351D, 48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC
  };

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  des_key_schedule_stream_if bus ();
  des_key_schedule_stream_if bus8 ();

  des_key_schedule_stream dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  des_key_schedule_stream #(.ROUNDS(8), .SHIFT_SCHED(16'h58AA)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.key_valid = 1'b1; bus.key = KEY_A; bus.decrypt = 1'b0; bus.sk_ready = 1'b1;
    bus8.key_valid = 1'b0; bus8.key = '0; bus8.decrypt = 1'b0; bus8.sk_ready = 1'b1;
    @(negedge clk); #1;
    total++; if (bus.key_ready !== 1'b0) begin bad++; $display("FAIL rst_key_ready got=%b want=0", bus.key_ready); end
    total++; if ({bus.sk_valid, bus.busy, bus.sk_last} !== 3'b000) begin
      bad++; $display("FAIL rst_ctl got=%b want=000", {bus.sk_valid, bus.busy, bus.sk_last}); end
    total++; if (bus.sk_round !== 4'd0) begin bad++; $display("FAIL rst_round got=%0d want=0", bus.sk_round); end
    total++; if (bus.sk_data !== 48'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.sk_data); end
    @(negedge clk);
    rst = 1'b0; bus.key_valid = 1'b0;
    #1;
    total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL idle_key_ready got=%b want=1", bus.key_ready); end
    total++; if (bus.sk_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", bus.sk_valid); end
  endtask

  task automatic test_enc();
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key = KEY_A; bus.decrypt = 1'b0; bus.sk_ready = 1'b1;
    #1;
    total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL enc_accept got=%b want=1", bus.key_ready); end
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      bus.key_valid = (b < 15); bus.key = ~KEY_A; bus.decrypt = 1'b1;
      #1;
      total++;
      if ({bus.sk_valid, bus.busy, bus.sk_round, bus.sk_last, bus.key_ready} !==
          {1'b1, 1'b1, 4'(b), (b == 15), (b == 15)}) begin
        bad++; $display("FAIL enc_ctl beat=%0d got=%b want=%b", b,
          {bus.sk_valid, bus.busy, bus.sk_round, bus.sk_last, bus.key_ready},
          {1'b1, 1'b1, 4'(b), (b == 15), (b == 15)});
      end
      total++; if (bus.sk_data !== ks_a[b]) begin
        bad++; $display("FAIL enc_data beat=%0d got=%h want=%h", b, bus.sk_data, ks_a[b]); end
    end
    @(negedge clk); bus.key_valid = 1'b0; #1;
    total++; if ({bus.sk_valid, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL enc_end got=%b want=00", {bus.sk_valid, bus.busy}); end
  endtask

  task automatic test_dec();
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key = KEY_A; bus.decrypt = 1'b1; bus.sk_ready = 1'b1;
    #1;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      bus.key_valid = 1'b0; bus.decrypt = 1'b0;
      #1;
      total++; if ({bus.sk_valid, bus.sk_round, bus.sk_last} !== {1'b1, 4'(b), (b == 15)}) begin
        bad++; $display("FAIL dec_ctl beat=%0d got=%b want=%b", b,
          {bus.sk_valid, bus.sk_round, bus.sk_last}, {1'b1, 4'(b), (b == 15)});
      end
      total++; if (bus.sk_data !== ks_a[15-b]) begin
        bad++; $display("FAIL dec_data beat=%0d got=%h want=%h", b, bus.sk_data, ks_a[15-b]); end
    end
    @(negedge clk); #1;
    total++; if (bus.sk_valid !== 1'b0) begin bad++; $display("FAIL dec_end got=%b want=0", bus.sk_valid); end
  endtask

  task automatic test_backpressure();
    logic [63:0] pat;
    int idx;
    int cyc;
    pat = 64'h9D3A_5C6B_E214_B78F;
    idx = 0;
    cyc = 0;
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key = KEY_A; bus.decrypt = 1'b0; bus.sk_ready = 1'b0;
    while (idx < 16 && cyc < 64) begin
      @(negedge clk);
      bus.key_valid = 1'b0; bus.sk_ready = pat[cyc];
      #1;
      total++; if ({bus.sk_valid, bus.sk_round, bus.sk_last} !== {1'b1, 4'(idx), (idx == 15)}) begin
        bad++; $display("FAIL bp_ctl cyc=%0d got=%b want=%b", cyc,
          {bus.sk_valid, bus.sk_round, bus.sk_last}, {1'b1, 4'(idx), (idx == 15)});
      end
      total++; if (bus.sk_data !== ks_a[idx]) begin
        bad++; $display("FAIL bp_data cyc=%0d got=%h want=%h", cyc, bus.sk_data, ks_a[idx]); end
      total++; if (bus.key_ready !== (pat[cyc] && idx == 15)) begin
        bad++; $display("FAIL bp_key_ready cyc=%0d got=%b want=%b", cyc, bus.key_ready, (pat[cyc] && idx == 15)); end
      if (pat[cyc]) idx++;
      cyc++;
    end
    total++; if (idx != 16) begin bad++; $display("FAIL bp_timeout got=%0d want=16", idx); end
    @(negedge clk); bus.sk_ready = 1'b1; #1;
    total++; if (bus.sk_valid !== 1'b0) begin bad++; $display("FAIL bp_end got=%b want=0", bus.sk_valid); end
  endtask

  task automatic test_reload();
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key = KEY_A; bus.decrypt = 1'b0; bus.sk_ready = 1'b1;
    for (int b = 0; b < 15; b++) begin
      @(negedge clk); bus.key_valid = 1'b0; #1;
      total++; if (bus.sk_data !== ks_a[b]) begin
        bad++; $display("FAIL rl_data_a beat=%0d got=%h want=%h", b, bus.sk_data, ks_a[b]); end
    end
    // last beat stalled while a new key waits: no reload may happen
    @(negedge clk);
    bus.sk_ready = 1'b0; bus.key_valid = 1'b1; bus.key = KEY_1; bus.decrypt = 1'b0;
    #1;
    total++; if ({bus.sk_round, bus.sk_last, bus.key_ready} !== {4'd15, 1'b1, 1'b0}) begin
      bad++; $display("FAIL rl_stall got=%b want=%b", {bus.sk_round, bus.sk_last, bus.key_ready}, {4'd15, 1'b1, 1'b0}); end
    @(negedge clk); bus.sk_ready = 1'b1; #1;
    total++; if (bus.key_ready !== 1'b1) begin bad++; $display("FAIL rl_key_ready got=%b want=1", bus.key_ready); end
    total++; if (bus.sk_data !== ks_a[15]) begin bad++; $display("FAIL rl_held got=%h want=%h", bus.sk_data, ks_a[15]); end
    for (int b = 0; b < 16; b++) begin
      @(negedge clk); bus.key_valid = 1'b0; #1;
      total++; if ({bus.sk_valid, bus.busy, bus.sk_round, bus.sk_last} !== {1'b1, 1'b1, 4'(b), (b == 15)}) begin
        bad++; $display("FAIL rl_ctl beat=%0d got=%b want=%b", b,
          {bus.sk_valid, bus.busy, bus.sk_round, bus.sk_last}, {1'b1, 1'b1, 4'(b), (b == 15)});
      end
      total++; if (bus.sk_data !== 48'hFFFF_FFFF_FFFF) begin
        bad++; $display("FAIL rl_data_b beat=%0d got=%h want=ffffffffffff", b, bus.sk_data); end
    end
    @(negedge clk); #1;
    total++; if (bus.sk_valid !== 1'b0) begin bad++; $display("FAIL rl_end got=%b want=0", bus.sk_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key = KEY_A; bus.decrypt = 1'b0; bus.sk_ready = 1'b1;
    for (int b = 0; b < 7; b++) begin
      @(negedge clk); bus.key_valid = 1'b0;
    end
    @(negedge clk); rst = 1'b1; #1;
    total++; if ({bus.sk_round, bus.key_ready} !== {4'd7, 1'b0}) begin
      bad++; $display("FAIL rm_beat7 got=%b want=%b", {bus.sk_round, bus.key_ready}, {4'd7, 1'b0}); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if ({bus.sk_valid, bus.busy, bus.sk_round, bus.key_ready} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin
      bad++; $display("FAIL rm_abort got=%b want=%b", {bus.sk_valid, bus.busy, bus.sk_round, bus.key_ready},
        {1'b0, 1'b0, 4'd0, 1'b1});
    end
    total++; if (bus.sk_data !== 48'h0) begin bad++; $display("FAIL rm_data got=%h want=0", bus.sk_data); end
    // fresh key differs from KEY_A only in parity bits, run in decrypt order
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key = KEY_P; bus.decrypt = 1'b1;
    for (int b = 0; b < 16; b++) begin
      @(negedge clk); bus.key_valid = 1'b0; #1;
      total++; if ({bus.sk_valid, bus.sk_round} !== {1'b1, 4'(b)}) begin
        bad++; $display("FAIL rm_ctl beat=%0d got=%b want=%b", b, {bus.sk_valid, bus.sk_round}, {1'b1, 4'(b)}); end
      total++; if (bus.sk_data !== ks_a[15-b]) begin
        bad++; $display("FAIL rm_data beat=%0d got=%h want=%h", b, bus.sk_data, ks_a[15-b]); end
    end
    @(negedge clk); #1;
    total++; if (bus.sk_valid !== 1'b0) begin bad++; $display("FAIL rm_end got=%b want=0", bus.sk_valid); end
  endtask

  task automatic test_params();
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      bus8.key_valid = 1'b1; bus8.key = KEY_A; bus8.decrypt = (m == 1); bus8.sk_ready = 1'b1;
      for (int b = 0; b < 8; b++) begin
        @(negedge clk); bus8.key_valid = 1'b0; #1;
        total++; if ({bus8.sk_valid, bus8.sk_round, bus8.sk_last} !== {1'b1, 4'(b), (b == 7)}) begin
          bad++; $display("FAIL p8_ctl mode=%0d beat=%0d got=%b want=%b", m, b,
            {bus8.sk_valid, bus8.sk_round, bus8.sk_last}, {1'b1, 4'(b), (b == 7)});
        end
        total++; if (bus8.sk_data !== ks_8[(m == 1) ? 7 - b : b]) begin
          bad++; $display("FAIL p8_data mode=%0d beat=%0d got=%h want=%h", m, b,
            bus8.sk_data, ks_8[(m == 1) ? 7 - b : b]);
        end
      end
      @(negedge clk); #1;
      total++; if ({bus8.sk_valid, bus8.busy} !== 2'b00) begin
        bad++; $display("FAIL p8_end mode=%0d got=%b want=00", m, {bus8.sk_valid, bus8.busy}); end
    end
  endtask

  initial begin
    test_reset();
    test_enc();
    test_dec();
    test_backpressure();
    test_reload();
    test_reset_mid();
    test_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
